count_sequencer: RTL and testbench

Command-driven controller that sequences an external up-counter through its `en`/`incr` control pair. It accepts a run command (step, length, tick divider) over a valid/ready handshake. It then issues exactly `length` single-cycle enable pulses carrying `step`, spaced by a programmable prescaler, and signals completion with a one-cycle `done` pulse. It sits between a host/stimulus source and the counter datapath and supports pause and abort.

---
 rtl/count_sequencer_if.sv | 15 +
 rtl/count_sequencer.sv | 93 +++++++++
 tb/tb_count_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/count_sequencer_if.sv
// Command channel of count_sequencer: a run command (step, length, tick divider)
// offered over a valid/ready handshake.
interface count_sequencer_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV_WIDTH = 16
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [WIDTH-1:0]     cmd_step;
  logic [WIDTH-1:0]     cmd_len;
  logic [DIV_WIDTH-1:0] cmd_div;

  modport master (output cmd_valid, cmd_step, cmd_len, cmd_div, input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_step, cmd_len, cmd_div, output cmd_ready);
endinterface

// File: rtl/count_sequencer.sv
// Sequences an external up-counter: issues `len` enable pulses carrying `step`,
// spaced by a prescaler, then a one-cycle done pulse. Supports pause and abort.
module count_sequencer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  count_sequencer_if.slave cmd,
  input  logic             pause,
  input  logic             abort,
  output logic             cnt_en,
  output logic [WIDTH-1:0] cnt_incr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] remaining
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nx;
  logic [WIDTH-1:0]     step_q, step_nx;
  logic [DIV_WIDTH-1:0] div_q, div_nx;
  logic [DIV_WIDTH-1:0] presc_q, presc_nx;
  logic [WIDTH-1:0]     rem_q, rem_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      step_q  <= '0;
      div_q   <= '0;
      presc_q <= '0;
      rem_q   <= '0;
    end else begin
      state   <= state_nx;
      step_q  <= step_nx;
      div_q   <= div_nx;
      presc_q <= presc_nx;
      rem_q   <= rem_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    step_nx       = step_q;
    div_nx        = div_q;
    presc_nx      = presc_q;
    rem_nx        = rem_q;
    cmd.cmd_ready = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    cnt_en        = 1'b0;
    cnt_incr      = '0;
    unique case (state)
      IDLE: begin
        cmd.cmd_ready = 1'b1;
        if (cmd.cmd_valid) begin
          step_nx  = cmd.cmd_step;
          div_nx   = cmd.cmd_div;
          presc_nx = cmd.cmd_div;
          rem_nx   = cmd.cmd_len;
          state_nx = (cmd.cmd_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy     = 1'b1;
        cnt_incr = step_q;
        // abort wins over pause and over a tick falling in the same cycle
        if (abort) begin
          rem_nx   = '0;
          state_nx = IDLE;
        end else if (!pause) begin
          if (presc_q == '0) begin
            cnt_en   = 1'b1;
            presc_nx = div_q;
            rem_nx   = rem_q - WIDTH'(1);
            if (rem_q == WIDTH'(1)) state_nx = DONE;
          end else begin
            presc_nx = presc_q - DIV_WIDTH'(1);
          end
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign remaining = rem_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: per-cycle comparison against a tick-schedule model
// plus directed scenarios with hand-computed expectations.
module tb_count_sequencer;
  localparam int unsigned W  = 8;
  localparam int unsigned DW = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         pause = 1'b0;
  logic         abort = 1'b0;
  logic         cnt_en;
  logic [W-1:0] cnt_incr;
  logic         busy;
  logic         done;
  logic [W-1:0] remaining;

  count_sequencer_if #(.WIDTH(W), .DIV_WIDTH(DW)) cif ();

  count_sequencer #(.WIDTH(W), .DIV_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cif.slave),
    .pause     (pause),
    .abort     (abort),
    .cnt_en    (cnt_en),
    .cnt_incr  (cnt_incr),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // External counter driven by the sequencer
  logic [W-1:0] ctr = '0;
  always @(posedge clk) if (cnt_en) ctr <= ctr + cnt_incr;

  // Model: in a run, a tick lands on every (div+1)-th unpaused, unaborted cycle
  int m_mode = 0;  // 0 idle, 1 run, 2 done
  int m_step = 0, m_len = 0, m_div = 0, m_act = 0;

  always @(negedge clk) begin
    int e_rdy, e_busy, e_done, e_en, e_incr, e_rem;
    if (rst) m_mode = 0;
    e_rdy = 0; e_busy = 0; e_done = 0; e_en = 0; e_incr = 0; e_rem = 0;
    case (m_mode)
      0: e_rdy = 1;
      1: begin
        e_busy = 1;
        e_incr = m_step;
        e_rem  = m_len - m_act / (m_div + 1);
        e_en   = (!pause && !abort && ((m_act + 1) % (m_div + 1) == 0)) ? 1 : 0;
      end
      default: e_done = 1;
    endcase
    check("cmd_ready", 32'(cif.cmd_ready), e_rdy);
    check("busy",      32'(busy),          e_busy);
    check("done",      32'(done),          e_done);
    check("cnt_en",    32'(cnt_en),        e_en);
    check("cnt_incr",  32'(cnt_incr),      e_incr);
    check("remaining", 32'(remaining),     e_rem);
    if (!rst) begin
      case (m_mode)
        0: if (cif.cmd_valid) begin
          m_step = int'(cif.cmd_step);
          m_len  = int'(cif.cmd_len);
          m_div  = int'(cif.cmd_div);
          m_act  = 0;
          m_mode = (m_len == 0) ? 2 : 1;
        end
        1: begin
          if (abort) m_mode = 0;
          else if (!pause) begin
            m_act++;
            if (m_act % (m_div + 1) == 0 && m_act / (m_div + 1) == m_len) m_mode = 2;
          end
        end
        default: m_mode = 0;
      endcase
    end
  end

  logic [W-1:0] rem_log [64];

  // One command; cycle 0 is the accept cycle, masks are indexed by cycle
  task automatic run_dir(input logic [W-1:0] st, input logic [W-1:0] ln, input logic [DW-1:0] dv,
                         input int ncyc, input logic [63:0] pmask, input logic [63:0] amask,
                         output logic [63:0] enm, output int done_c, output int ready_c,
                         output logic [W-1:0] delta);
    logic [W-1:0] c0;
    @(posedge clk); #1;
    c0 = ctr;
    cif.cmd_valid = 1'b1;
    cif.cmd_step  = st;
    cif.cmd_len   = ln;
    cif.cmd_div   = dv;
    enm = '0; done_c = -1; ready_c = -1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      cif.cmd_valid = 1'b0;
      pause = pmask[c];
      abort = amask[c];
      #1;
      if (cnt_en) enm[c] = 1'b1;
      rem_log[c] = remaining;
      if (done && done_c < 0) done_c = c;
      if (cif.cmd_ready && ready_c < 0) ready_c = c;
    end
    pause = 1'b0;
    abort = 1'b0;
    @(posedge clk); #1;
    delta = ctr - c0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0]  enm;
    int           dc, rc, n_en;
    logic [W-1:0] dl, c0;

    cif.cmd_valid = 1'b0;
    cif.cmd_step  = '0;
    cif.cmd_len   = '0;
    cif.cmd_div   = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_ready",  32'(cif.cmd_ready), 1);
    check("rst_en",     32'(cnt_en), 0);
    check("rst_incr",   32'(cnt_incr), 0);
    check("rst_busy",   32'(busy), 0);
    check("rst_done",   32'(done), 0);
    check("rst_rem",    32'(remaining), 0);
    #20 rst = 1'b0;

    // step 3, len 4, div 0
    run_dir(8'd3, 8'd4, 16'd0, 8, 64'h0, 64'h0, enm, dc, rc, dl);
    check("t1_en_mask", enm[31:0], 32'h1E);
    check("t1_done",    dc, 5);
    check("t1_ready",   rc, 6);
    check("t1_delta",   32'(dl), 12);

    // step 1, len 3, div 2
    run_dir(8'd1, 8'd3, 16'd2, 12, 64'h0, 64'h0, enm, dc, rc, dl);
    check("t2_en_mask", enm[31:0], 32'h248);
    check("t2_done",    dc, 10);
    check("t2_rem1",    32'(rem_log[1]), 3);
    check("t2_rem4",    32'(rem_log[4]), 2);
    check("t2_rem7",    32'(rem_log[7]), 1);
    check("t2_rem10",   32'(rem_log[10]), 0);

    // zero-length command
    run_dir(8'd7, 8'd0, 16'd0, 4, 64'h0, 64'h0, enm, dc, rc, dl);
    check("t3_en_mask", enm[31:0], 0);
    check("t3_done",    dc, 1);
    check("t3_ready",   rc, 2);
    check("t3_delta",   32'(dl), 0);

    // pause cycles 2..4
    run_dir(8'd1, 8'd5, 16'd0, 12, 64'h1C, 64'h0, enm, dc, rc, dl);
    check("t4_en_mask", enm[31:0], 32'h1E2);
    check("t4_rem2",    32'(rem_log[2]), 4);
    check("t4_rem4",    32'(rem_log[4]), 4);
    check("t4_done",    dc, 9);
    check("t4_delta",   32'(dl), 5);

    // abort and pause together at cycle 3
    run_dir(8'd2, 8'd10, 16'd0, 8, 64'h8, 64'h8, enm, dc, rc, dl);
    check("t5_en_mask", enm[31:0], 32'h6);
    check("t5_no_done", dc, -1);
    check("t5_ready",   rc, 4);
    check("t5_rem4",    32'(rem_log[4]), 0);
    check("t5_delta",   32'(dl), 4);

    // wrap: 200*2 mod 256
    run_dir(8'd200, 8'd2, 16'd0, 5, 64'h0, 64'h0, enm, dc, rc, dl);
    check("t6_delta",   32'(dl), 144);
    check("t6_done",    dc, 3);

    // asynchronous reset in the middle of a run
    @(posedge clk); #1;
    cif.cmd_valid = 1'b1; cif.cmd_step = 8'd5; cif.cmd_len = 8'd10; cif.cmd_div = 16'd0;
    @(posedge clk); #1;
    cif.cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("t6_busy_pre", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_en",    32'(cnt_en), 0);
    check("t6_rst_incr",  32'(cnt_incr), 0);
    check("t6_rst_busy",  32'(busy), 0);
    check("t6_rst_rem",   32'(remaining), 0);
    check("t6_rst_ready", 32'(cif.cmd_ready), 1);
    @(posedge clk); #3 rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      cif.cmd_valid = ($urandom_range(0, 2) == 0);
      cif.cmd_step  = W'($urandom);
      cif.cmd_len   = W'($urandom_range(0, 6));
      cif.cmd_div   = ($urandom_range(0, 7) == 0) ? DW'($urandom_range(4, 20)) : DW'($urandom_range(0, 3));
      pause         = ($urandom_range(0, 4) == 0);
      abort         = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk); #1;
    cif.cmd_valid = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
    repeat (200) @(posedge clk);

    // maximum length run
    #1;
    c0 = ctr;
    cif.cmd_valid = 1'b1; cif.cmd_step = 8'd1; cif.cmd_len = 8'd255; cif.cmd_div = 16'd0;
    n_en = 0; dc = -1;
    for (int c = 1; c <= 260; c++) begin
      @(posedge clk); #1;
      cif.cmd_valid = 1'b0;
      #1;
      if (cnt_en) n_en++;
      if (done && dc < 0) dc = c;
    end
    check("max_ticks", n_en, 255);
    check("max_done",  dc, 256);
    check("max_delta", 32'(W'(ctr - c0)), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
